proc_core_mc: RTL and testbench
===============================

Name: proc_core_mc

Overview:
Parametrised multi-cycle successor to the single-cycle 16-bit processor core. It fetches 16-bit instructions through a req/valid instruction-memory handshake, so memory may take any number of wait states. It runs a FETCH/DECODE/EXECUTE/WRITEBACK state machine over an internal register file. Beyond the single-cycle core, it adds a conditional branch, an absolute jump, load-immediate, HALT, and a retire/trace port for verification.

Parameters:
DATA_W, 16, register and ALU width in bits; legal range 16 to 64.
PC_W, 10, program counter and instruction address width in bits; legal range 4 to 16.
NREG, 8, number of general registers; fixed at 8 because instruction fields are 3 bits.

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous active-low reset
imem_req  output  1  fetch request; held high while waiting for the instruction
imem_addr  output  PC_W  fetch address; equals pc while imem_req is high
imem_rdata  input  16  instruction word; sampled only when imem_req && imem_valid
imem_valid  input  1  memory response strobe
pc  output  PC_W  current program counter
halted  output  1  high in the HALT state
retire  output  1  one-cycle pulse per completed instruction
retire_we  output  1  the retiring instruction wrote a register
retire_waddr  output  3  destination register of the retiring instruction
retire_wdata  output  DATA_W  value written to the destination register
retire_pc  output  PC_W  address of the retiring instruction

Behaviour:
- Reset: one clock and one reset. Reset is synchronous and active-low: sampled on the rising clk edge while reset==0.
- Reset values: pc=0, all registers=0, state=FETCH, imem_req=0, halted=0, retire=0, retire_we=0, retire_waddr=0, retire_wdata=0, retire_pc=0.
- imem_req rises on the first cycle after reset deasserts.
- Reset mid-operation (any state, including HALT and an outstanding fetch): the core returns to the reset values on the next edge. A late imem_valid after that reset is ignored.
- Instruction fields: op=[15:13], rd=[12:10], rs1=[9:7], rs2=[2:0], imm4=[3:0], off7=[6:0] (signed), tgt=[9:0], imm10=[9:0].
- Opcodes:
  - 000 ADD: rd=rs1+rs2.
  - 001 SUB: rd=rs1-rs2.
  - 010 ADDI: rd=rs1+zext(imm4).
  - 011 SUBI: rd=rs1-zext(imm4).
  - 100 BEQZ: if rs1==0 then pc=pc+sext(off7), else pc=pc+1.
  - 101 JMP: pc=tgt truncated or zero-extended to PC_W.
  - 110 LDI: rd=zext(imm10).
  - 111 HALT.
- Arithmetic: modulo 2^DATA_W; no flags or traps. PC arithmetic is modulo 2^PC_W, so wrap-around is legal in both directions.
- Register file: r0 is an ordinary writable register.
- FSM:
  - FETCH: imem_req=1, imem_addr=pc. Wait until imem_valid, then latch imem_rdata into the instruction register and go to DECODE. The valid strobe may arrive in the same cycle as the request. imem_valid while imem_req==0 is ignored.
  - DECODE: imem_req=0. Read rs1/rs2 into operand registers and form operand B (immediate or rs2). Go to EXECUTE.
  - EXECUTE: compute the ALU result, next_pc, and write-enable. HALT goes to the HALT state without retiring. All others go to WRITEBACK.
  - WRITEBACK: write rd if enabled, update pc=next_pc, pulse retire with the trace fields. Go to FETCH.
  - HALT: halted=1, imem_req=0, pc frozen, registers frozen. Exit only by reset.
- Latency: 4 cycles per instruction with zero-wait memory (valid in the same cycle as req); each memory wait cycle adds 1.
- Trace outputs are valid only while retire=1 and hold their previous values otherwise.
- Branches and jumps pulse retire with retire_we=0; retire_waddr/retire_wdata then hold their previous values.
- A write to rd takes effect before the next instruction's DECODE, so back-to-back dependencies need no forwarding or stall.
- DATA_W>16: immediates are zero-extended to DATA_W; LDI loads at most 10 bits.

Test Plan:
- Zero-wait memory. Program: LDI r1,5; ADDI r2,r1,3; SUB r3,r2,r1; HALT. Expect retire pulses at cycles 4, 8, 12 after reset release with wdata 5, 8, 3; halted=1 and imem_req=0 from then on; pc stays at 3.
- Wait states: memory answers 3 cycles after req with the same program. Expect instruction spacing of 7 cycles, identical retire data, and imem_addr stable while imem_req is high.
- BEQZ taken and not taken: r1=0, BEQZ r1,-2 at pc=6 gives next pc=4. With r1=1, next pc=7. Both retire with retire_we=0 and retire_pc=6.
- Wrap-around: DATA_W=16, r1=0xFFFF, ADDI r1,r1,1 gives r1=0. JMP 0x3FF then a non-branch instruction gives pc=0 (PC_W=10).
- Reset mid-fetch: assert reset while imem_req=1, then pulse imem_valid during reset. Expect all outputs at reset values, the next fetch at pc=0, and the late response ignored.
- Parameter sweep: DATA_W=32, PC_W=12. SUBI r1,r0,1 gives 0xFFFFFFFF. LDI 0x3FF gives 0x000003FF.

Source files
------------

// File: rtl/proc_core_mc.sv
// Multi-cycle 16-bit-instruction processor core with a req/valid fetch port and a retire trace.
// FETCH/DECODE/EXECUTE/WRITEBACK sequencing over an 8-entry register file.
module proc_core_mc #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned PC_W   = 10,
  parameter int unsigned NREG   = 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [15:0]       imem_rdata,
  input  logic              imem_valid,
  output logic [PC_W-1:0]   pc,
  output logic              halted,
  output logic              retire,
  output logic              retire_we,
  output logic [2:0]        retire_waddr,
  output logic [DATA_W-1:0] retire_wdata,
  output logic [PC_W-1:0]   retire_pc
);

  localparam logic [2:0] StFetch     = 3'd0;
  localparam logic [2:0] StDecode    = 3'd1;
  localparam logic [2:0] StExecute   = 3'd2;
  localparam logic [2:0] StWriteback = 3'd3;
  localparam logic [2:0] StHalt      = 3'd4;

  localparam logic [2:0] OpAdd  = 3'd0;
  localparam logic [2:0] OpSub  = 3'd1;
  localparam logic [2:0] OpAddi = 3'd2;
  localparam logic [2:0] OpSubi = 3'd3;
  localparam logic [2:0] OpBeqz = 3'd4;
  localparam logic [2:0] OpJmp  = 3'd5;
  localparam logic [2:0] OpLdi  = 3'd6;
  localparam logic [2:0] OpHalt = 3'd7;

  logic [2:0]        state_q, state_d;
  logic              run_q;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   npc_q, npc_d;
  logic [15:0]       ir_q, ir_d;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] regs_q [NREG];
  logic              rf_we;

  logic              retire_q, retire_d;
  logic              rt_we_q, rt_we_d;
  logic [2:0]        rt_waddr_q, rt_waddr_d;
  logic [DATA_W-1:0] rt_wdata_q, rt_wdata_d;
  logic [PC_W-1:0]   rt_pc_q, rt_pc_d;

  logic [2:0]        op, rd, rs1, rs2;
  logic [15:0]       off_sext;
  logic [PC_W-1:0]   br_off, jmp_tgt, pc_inc;
  logic [DATA_W-1:0] imm4_ext, imm10_ext;

  assign op        = ir_q[15:13];
  assign rd        = ir_q[12:10];
  assign rs1       = ir_q[9:7];
  assign rs2       = ir_q[2:0];
  assign off_sext  = {{9{ir_q[6]}}, ir_q[6:0]};
  assign br_off    = PC_W'(off_sext);
  assign jmp_tgt   = PC_W'(ir_q[9:0]);
  assign pc_inc    = pc_q + PC_W'(1);
  assign imm4_ext  = DATA_W'(ir_q[3:0]);
  assign imm10_ext = DATA_W'(ir_q[9:0]);

  // run_q keeps the request low during the first cycle out of reset.
  assign imem_req     = run_q && (state_q == StFetch);
  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign halted       = (state_q == StHalt);
  assign retire       = retire_q;
  assign retire_we    = rt_we_q;
  assign retire_waddr = rt_waddr_q;
  assign retire_wdata = rt_wdata_q;
  assign retire_pc    = rt_pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    npc_d      = npc_q;
    ir_d       = ir_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    res_d      = res_q;
    we_d       = we_q;
    rf_we      = 1'b0;
    retire_d   = 1'b0;
    rt_we_d    = rt_we_q;
    rt_waddr_d = rt_waddr_q;
    rt_wdata_d = rt_wdata_q;
    rt_pc_d    = rt_pc_q;

    unique case (state_q)
      StFetch: begin
        if (imem_req && imem_valid) begin
          ir_d    = imem_rdata;
          state_d = StDecode;
        end
      end
      StDecode: begin
        opa_d   = regs_q[rs1];
        opb_d   = (op == OpAddi || op == OpSubi) ? imm4_ext : regs_q[rs2];
        state_d = StExecute;
      end
      StExecute: begin
        res_d = opa_q;
        we_d  = 1'b0;
        npc_d = pc_inc;
        case (op)
          OpAdd, OpAddi: begin
            res_d = opa_q + opb_q;
            we_d  = 1'b1;
          end
          OpSub, OpSubi: begin
            res_d = opa_q - opb_q;
            we_d  = 1'b1;
          end
          OpBeqz: begin
            if (opa_q == '0) npc_d = pc_q + br_off;
          end
          OpJmp: npc_d = jmp_tgt;
          OpLdi: begin
            res_d = imm10_ext;
            we_d  = 1'b1;
          end
          default: ;
        endcase
        state_d = (op == OpHalt) ? StHalt : StWriteback;
      end
      StWriteback: begin
        rf_we    = we_q;
        pc_d     = npc_q;
        retire_d = 1'b1;
        rt_we_d  = we_q;
        rt_pc_d  = pc_q;
        // Branches leave the last written register/value on the trace port.
        if (we_q) begin
          rt_waddr_d = rd;
          rt_wdata_d = res_q;
        end
        state_d = StFetch;
      end
      StHalt: ;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StFetch;
      run_q      <= 1'b0;
      pc_q       <= '0;
      npc_q      <= '0;
      ir_q       <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      res_q      <= '0;
      we_q       <= 1'b0;
      retire_q   <= 1'b0;
      rt_we_q    <= 1'b0;
      rt_waddr_q <= '0;
      rt_wdata_q <= '0;
      rt_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      run_q      <= 1'b1;
      pc_q       <= pc_d;
      npc_q      <= npc_d;
      ir_q       <= ir_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      res_q      <= res_d;
      we_q       <= we_d;
      retire_q   <= retire_d;
      rt_we_q    <= rt_we_d;
      rt_waddr_q <= rt_waddr_d;
      rt_wdata_q <= rt_wdata_d;
      rt_pc_q    <= rt_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
    end else if (rf_we) begin
      regs_q[rd] <= res_q;
    end
  end

endmodule

// File: tb/tb_proc_core_mc.sv
// Bench for proc_core_mc: table-driven programs with a retire scoreboard, wait-state memory,
// mid-fetch reset, and a second DATA_W=32/PC_W=12 instance.
module tb_proc_core_mc;

  typedef struct {
    int          addr;
    logic [15:0] instr;
    logic        we;
    logic [2:0]  waddr;
    logic [31:0] wdata;
  } vec_t;

  typedef struct {
    int          pc;
    logic        we;
    logic [2:0]  waddr;
    logic [31:0] wdata;
    int          cyc;
  } sb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b0;
  logic reset2 = 1'b0;

  logic        imem_req, imem_valid, halted, retire, retire_we;
  logic [9:0]  imem_addr, pc, retire_pc;
  logic [15:0] imem_rdata, retire_wdata;
  logic [2:0]  retire_waddr;

  logic        imem_req2, imem_valid2, halted2, retire2, retire_we2;
  logic [11:0] imem_addr2, pc2, retire_pc2;
  logic [15:0] imem_rdata2;
  logic [31:0] retire_wdata2;
  logic [2:0]  retire_waddr2;

  logic [15:0] mem [0:1023];
  logic [15:0] mem2 [0:4095];
  int          mem_wait = 0;
  int          wait_cnt = 0;
  logic        mem_valid = 1'b0;
  logic [15:0] mem_rdata = 16'h0;
  logic        manual = 1'b0;
  logic        man_valid = 1'b0;
  logic [15:0] man_rdata = 16'h0;
  logic        prev_req = 1'b0;
  logic [9:0]  prev_addr = 10'h0;

  int   n_checks = 0;
  int   n_err = 0;
  int   cyc = -1;
  sb_t  q[$];
  sb_t  q2[$];
  sb_t  e1, e2;
  vec_t tbl [0:23];
  vec_t tbl2 [0:4];

  assign imem_valid  = manual ? man_valid : mem_valid;
  assign imem_rdata  = manual ? man_rdata : mem_rdata;
  assign imem_valid2 = imem_req2;
  assign imem_rdata2 = mem2[imem_addr2];

  proc_core_mc dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_valid   (imem_valid),
    .pc           (pc),
    .halted       (halted),
    .retire       (retire),
    .retire_we    (retire_we),
    .retire_waddr (retire_waddr),
    .retire_wdata (retire_wdata),
    .retire_pc    (retire_pc)
  );

  proc_core_mc #(.DATA_W(32), .PC_W(12), .NREG(8)) dut2 (
    .clk          (clk),
    .reset        (reset2),
    .imem_req     (imem_req2),
    .imem_addr    (imem_addr2),
    .imem_rdata   (imem_rdata2),
    .imem_valid   (imem_valid2),
    .pc           (pc2),
    .halted       (halted2),
    .retire       (retire2),
    .retire_we    (retire_we2),
    .retire_waddr (retire_waddr2),
    .retire_wdata (retire_wdata2),
    .retire_pc    (retire_pc2)
  );

  task automatic chk(input bit ok, input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] alur(input logic [2:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, 4'b0000, rs2};
  endfunction

  function automatic logic [15:0] alui(input logic [2:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [3:0] imm);
    return {op, rd, rs1, 3'b000, imm};
  endfunction

  function automatic logic [15:0] beqz(input logic [2:0] rs1, input logic [6:0] off);
    return {3'b100, 3'b000, rs1, off};
  endfunction

  function automatic logic [15:0] jmp(input logic [9:0] tgt);
    return {3'b101, 3'b000, tgt};
  endfunction

  function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [9:0] imm);
    return {3'b110, rd, imm};
  endfunction

  function automatic vec_t mk(input int a, input logic [15:0] i, input logic we,
                              input logic [2:0] wa, input logic [31:0] wd);
    vec_t v;
    v.addr = a; v.instr = i; v.we = we; v.waddr = wa; v.wdata = wd;
    return v;
  endfunction

  // Cycle 0 is the first rising edge that samples reset released.
  always @(posedge clk) begin
    if (!reset) cyc = -1;
    else cyc = cyc + 1;
  end

  // Instruction memory with mem_wait cycles of latency; the address must hold while requesting.
  always @(negedge clk) begin
    if (reset && imem_req) begin
      if (prev_req) chk(imem_addr == prev_addr, "imem_addr_stable", 64'(imem_addr), 64'(prev_addr));
      if (wait_cnt >= mem_wait) begin
        mem_valid = 1'b1;
        mem_rdata = mem[imem_addr];
        wait_cnt  = 0;
      end else begin
        mem_valid = 1'b0;
        wait_cnt  = wait_cnt + 1;
      end
    end else begin
      mem_valid = 1'b0;
      wait_cnt  = 0;
    end
    prev_req  = reset && imem_req;
    prev_addr = imem_addr;
  end

  always @(negedge clk) begin
    if (reset && retire) begin
      if (q.size() == 0) begin
        chk(1'b0, "unexpected_retire", 64'(retire_pc), 64'(0));
      end else begin
        e1 = q.pop_front();
        chk({retire_pc, retire_we, retire_waddr, retire_wdata, 16'(cyc)} ==
            {e1.pc[9:0], e1.we, e1.waddr, e1.wdata[15:0], 16'(e1.cyc)}, "retire_trace",
            64'({16'(retire_pc), 4'(retire_we), 4'(retire_waddr), retire_wdata, 16'(cyc)}),
            64'({16'(e1.pc), 4'(e1.we), 4'(e1.waddr), e1.wdata[15:0], 16'(e1.cyc)}));
      end
    end
  end

  always @(negedge clk) begin
    if (reset2 && retire2) begin
      if (q2.size() == 0) begin
        chk(1'b0, "unexpected_retire_w32", 64'(retire_pc2), 64'(0));
      end else begin
        e2 = q2.pop_front();
        chk({retire_pc2, retire_we2, retire_waddr2, retire_wdata2} ==
            {e2.pc[11:0], e2.we, e2.waddr, e2.wdata}, "retire_trace_w32",
            64'({16'(retire_pc2), 4'(retire_we2), 4'(retire_waddr2), retire_wdata2}),
            64'({16'(e2.pc), 4'(e2.we), 4'(e2.waddr), e2.wdata}));
      end
    end
  end

  task automatic check_reset();
    chk({imem_req, halted, retire, retire_we, retire_waddr, retire_wdata, retire_pc, pc} == '0,
        "reset_values",
        64'({imem_req, halted, retire, retire_we, retire_waddr, retire_wdata, retire_pc, pc}),
        64'(0));
  endtask

  task automatic start_phase(input int first, input int n, input int w);
    vec_t        v;
    logic [2:0]  lw;
    logic [31:0] ld;
    @(negedge clk);
    reset    = 1'b0;
    manual   = 1'b0;
    mem_wait = w;
    for (int a = 0; a < 1024; a++) mem[a] = 16'hE000;
    q.delete();
    lw = 3'd0;
    ld = 32'd0;
    for (int k = 0; k < n; k++) begin
      v = tbl[first + k];
      mem[v.addr] = v.instr;
      if (v.we) begin
        lw = v.waddr;
        ld = v.wdata;
      end
      q.push_back('{pc: v.addr, we: v.we, waddr: lw, wdata: ld, cyc: (k + 1) * (4 + w)});
    end
    @(negedge clk);
    @(negedge clk);
    check_reset();
    reset = 1'b1;
    @(negedge clk);
    chk(imem_req && imem_addr == 10'd0, "first_fetch", 64'({imem_req, imem_addr}),
        64'({1'b1, 10'd0}));
  endtask

  task automatic finish_phase(input int halt_addr);
    int t;
    t = 0;
    while (!halted && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk(halted, "reach_halt", 64'(halted), 64'(1));
    repeat (5) @(negedge clk);
    chk(q.size() == 0, "all_retired", 64'(q.size()), 64'(0));
    chk(halted && !imem_req && pc == 10'(halt_addr), "halt_state",
        64'({halted, imem_req, pc}), 64'({1'b1, 1'b0, 10'(halt_addr)}));
  endtask

  initial begin
    int          t;
    logic [2:0]  lw;
    logic [31:0] ld;

    // Test-plan program
    tbl[0]  = mk(0, ldi(3'd1, 10'd5), 1'b1, 3'd1, 32'd5);
    tbl[1]  = mk(1, alui(3'b010, 3'd2, 3'd1, 4'd3), 1'b1, 3'd2, 32'd8);
    tbl[2]  = mk(2, alur(3'b001, 3'd3, 3'd2, 3'd1), 1'b1, 3'd3, 32'd3);
    // Jumps, BEQZ taken backwards then not taken, r0 writes
    tbl[3]  = mk(0, ldi(3'd1, 10'd5), 1'b1, 3'd1, 32'd5);
    tbl[4]  = mk(1, alui(3'b010, 3'd2, 3'd1, 4'd3), 1'b1, 3'd2, 32'd8);
    tbl[5]  = mk(2, alur(3'b001, 3'd3, 3'd2, 3'd1), 1'b1, 3'd3, 32'd3);
    tbl[6]  = mk(3, jmp(10'd5), 1'b0, 3'd0, 32'd0);
    tbl[7]  = mk(5, alur(3'b000, 3'd4, 3'd3, 3'd2), 1'b1, 3'd4, 32'd11);
    tbl[8]  = mk(6, beqz(3'd6, 7'h7E), 1'b0, 3'd0, 32'd0);
    tbl[9]  = mk(4, ldi(3'd6, 10'd1), 1'b1, 3'd6, 32'd1);
    tbl[10] = mk(5, alur(3'b000, 3'd4, 3'd3, 3'd2), 1'b1, 3'd4, 32'd11);
    tbl[11] = mk(6, beqz(3'd6, 7'h7E), 1'b0, 3'd0, 32'd0);
    tbl[12] = mk(7, ldi(3'd0, 10'h2AA), 1'b1, 3'd0, 32'h2AA);
    tbl[13] = mk(8, alur(3'b000, 3'd7, 3'd0, 3'd0), 1'b1, 3'd7, 32'h554);
    tbl[14] = mk(9, alur(3'b001, 3'd7, 3'd1, 3'd2), 1'b1, 3'd7, 32'hFFFD);
    // Wait-state run with data and pc wrap-around
    tbl[15] = mk(0, beqz(3'd1, 7'd5), 1'b0, 3'd0, 32'd0);
    tbl[16] = mk(5, ldi(3'd1, 10'd5), 1'b1, 3'd1, 32'd5);
    tbl[17] = mk(6, alui(3'b010, 3'd2, 3'd1, 4'd3), 1'b1, 3'd2, 32'd8);
    tbl[18] = mk(7, alur(3'b001, 3'd3, 3'd2, 3'd1), 1'b1, 3'd3, 32'd3);
    tbl[19] = mk(8, alui(3'b011, 3'd4, 3'd0, 4'd1), 1'b1, 3'd4, 32'hFFFF);
    tbl[20] = mk(9, alui(3'b010, 3'd4, 3'd4, 4'd1), 1'b1, 3'd4, 32'h0);
    tbl[21] = mk(10, jmp(10'h3FF), 1'b0, 3'd0, 32'd0);
    tbl[22] = mk(1023, alui(3'b010, 3'd5, 3'd1, 4'd15), 1'b1, 3'd5, 32'd20);
    tbl[23] = mk(0, beqz(3'd1, 7'd5), 1'b0, 3'd0, 32'd0);
    // DATA_W=32, PC_W=12 instance
    tbl2[0] = mk(0, alui(3'b011, 3'd1, 3'd0, 4'd1), 1'b1, 3'd1, 32'hFFFF_FFFF);
    tbl2[1] = mk(1, ldi(3'd2, 10'h3FF), 1'b1, 3'd2, 32'h3FF);
    tbl2[2] = mk(2, alur(3'b000, 3'd3, 3'd1, 3'd2), 1'b1, 3'd3, 32'h3FE);
    tbl2[3] = mk(3, jmp(10'h3FF), 1'b0, 3'd0, 32'd0);
    tbl2[4] = mk(1023, alui(3'b010, 3'd4, 3'd2, 4'd1), 1'b1, 3'd4, 32'h400);

    for (int a = 0; a < 4096; a++) mem2[a] = 16'hE000;
    lw = 3'd0;
    ld = 32'd0;
    for (int k = 0; k < 5; k++) begin
      mem2[tbl2[k].addr] = tbl2[k].instr;
      if (tbl2[k].we) begin
        lw = tbl2[k].waddr;
        ld = tbl2[k].wdata;
      end
      q2.push_back('{pc: tbl2[k].addr, we: tbl2[k].we, waddr: lw, wdata: ld, cyc: 0});
    end

    repeat (2) @(negedge clk);
    chk({imem_req2, halted2, retire2, retire_we2, retire_waddr2, retire_wdata2, retire_pc2, pc2}
        == '0, "reset_values_w32",
        64'({imem_req2, halted2, retire2, retire_we2, retire_waddr2, retire_wdata2}), 64'(0));
    reset2 = 1'b1;

    start_phase(0, 3, 0);
    finish_phase(3);
    start_phase(3, 12, 0);
    finish_phase(10);
    start_phase(15, 9, 3);
    finish_phase(1);

    // Reset while a fetch is outstanding, with the response arriving during reset
    start_phase(0, 3, 3);
    t = 0;
    while (q.size() > 2 && t < 100) begin
      @(negedge clk);
      t++;
    end
    while (!imem_req && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk(imem_req && q.size() == 2, "midfetch_setup", 64'({imem_req, 8'(q.size())}),
        64'({1'b1, 8'd2}));
    reset     = 1'b0;
    manual    = 1'b1;
    man_valid = 1'b1;
    man_rdata = ldi(3'd7, 10'h155);
    @(negedge clk);
    check_reset();
    man_valid = 1'b0;
    q.delete();
    start_phase(0, 3, 0);
    finish_phase(3);

    t = 0;
    while (!halted2 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk(halted2 && !imem_req2 && pc2 == 12'd1024 && q2.size() == 0, "halt_state_w32",
        64'({halted2, imem_req2, pc2, 8'(q2.size())}), 64'({1'b1, 1'b0, 12'd1024, 8'd0}));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
